// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scanout
//  Description : Display-side framebuffer reader. Generates raster timing
//                (640x480@60 by default), fetches one 32-bit framebuffer word
//                one cycle ahead of the first of its four pixels, unpacks
//                four RGB332 pixels per word, and drives registered
//                hsync/vsync/de/rgb/frame_start to the DAC stage.
//  Revision    : 1.0  - initial release
// ============================================================================
module vga_scanout #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE    = '0,
  parameter int                    H_ACTIVE   = 640,
  parameter int                    H_FP       = 16,
  parameter int                    H_SYNC     = 96,
  parameter int                    H_BP       = 48,
  parameter int                    V_ACTIVE   = 480,
  parameter int                    V_FP       = 10,
  parameter int                    V_SYNC     = 2,
  parameter int                    V_BP       = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fb_ren,
  output logic [ADDR_WIDTH-1:0] fb_raddr,
  input  logic [DATA_WIDTH-1:0] fb_rdata,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [7:0]            rgb,
  output logic                  frame_start
);

  // --------------------------------------------------------------------------
  // Derived geometry. Counter widths carry one bit of headroom so every
  // region boundary (including the totals themselves) is representable.
  // --------------------------------------------------------------------------
  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_hw      = $clog2(c_h_total + 1);
  localparam int c_vw      = $clog2(c_v_total + 1);
  localparam int c_words   = (H_ACTIVE * V_ACTIVE) / 4;
  localparam int c_iw      = (c_words > 1) ? $clog2(c_words) : 1;

  localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
  localparam logic [c_hw-1:0] c_h_act      = c_hw'(H_ACTIVE);
  localparam logic [c_hw-1:0] c_hs_start   = c_hw'(H_ACTIVE + H_FP);
  localparam logic [c_hw-1:0] c_hs_end     = c_hw'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_hw-1:0] c_h_one      = c_hw'(1);

  localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
  localparam logic [c_vw-1:0] c_v_act      = c_vw'(V_ACTIVE);
  localparam logic [c_vw-1:0] c_vs_start   = c_vw'(V_ACTIVE + V_FP);
  localparam logic [c_vw-1:0] c_vs_end     = c_vw'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [c_vw-1:0] c_v_one      = c_vw'(1);

  localparam logic [c_iw-1:0] c_idx_last   = c_iw'(c_words - 1);
  localparam logic [c_iw-1:0] c_idx_one    = c_iw'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_hw-1:0]         h_cnt_q,    h_cnt_d;
  logic [c_vw-1:0]         v_cnt_q,    v_cnt_d;
  logic [c_iw-1:0]         word_idx_q, word_idx_d;
  // Byte 0 of each word is consumed straight from fb_rdata, so only the
  // three upper bytes need to be held for the following three pixels.
  logic [DATA_WIDTH-1:8]   word_q,     word_d;

  logic                    hsync_q,       hsync_d;
  logic                    vsync_q,       vsync_d;
  logic                    de_q,          de_d;
  logic [7:0]              rgb_q,         rgb_d;
  logic                    frame_start_q, frame_start_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                    w_h_wrap;
  logic                    w_v_wrap;
  logic                    w_nxt_active;
  logic                    w_cur_active;
  logic                    w_hs_region;
  logic                    w_vs_region;
  logic [1:0]              w_lane;
  logic [7:0]              w_pixel;

  // Raster counters: h wraps every line, v steps on each h wrap.
  always_comb begin
    w_h_wrap = (h_cnt_q == c_h_last);
    w_v_wrap = (v_cnt_q == c_v_last);

    h_cnt_d = w_h_wrap ? '0 : (h_cnt_q + c_h_one);

    v_cnt_d = v_cnt_q;
    if (w_h_wrap) begin
      v_cnt_d = w_v_wrap ? '0 : (v_cnt_q + c_v_one);
    end
  end

  // Prefetch: request the word whose first pixel lands on the next counter
  // position, so the data arrives exactly when that pixel is displayed.
  always_comb begin
    w_nxt_active = (h_cnt_d < c_h_act) && (v_cnt_d < c_v_act);
    fb_ren       = ~rst & w_nxt_active & (h_cnt_d[1:0] == 2'b00);

    word_idx_d = word_idx_q;
    if (fb_ren) begin
      word_idx_d = (word_idx_q == c_idx_last) ? '0 : (word_idx_q + c_idx_one);
    end

    fb_raddr = FB_BASE + ADDR_WIDTH'(word_idx_q);
  end

  // Unpack: lane 0 comes from the freshly returned word, lanes 1..3 from the
  // copy captured alongside it.
  always_comb begin
    w_cur_active = (h_cnt_q < c_h_act) && (v_cnt_q < c_v_act);
    w_lane       = h_cnt_q[1:0];

    word_d = word_q;
    if (w_cur_active && (w_lane == 2'd0)) begin
      word_d = fb_rdata[DATA_WIDTH-1:8];
    end

    case (w_lane)
      2'd0:    w_pixel = fb_rdata[7:0];
      2'd1:    w_pixel = word_q[15:8];
      2'd2:    w_pixel = word_q[23:16];
      default: w_pixel = word_q[31:24];
    endcase
  end

  // Output stage next-state: every DAC-facing signal is derived from the
  // same counter position so all of them share one cycle of latency.
  always_comb begin
    w_hs_region   = (h_cnt_q >= c_hs_start) && (h_cnt_q < c_hs_end);
    w_vs_region   = (v_cnt_q >= c_vs_start) && (v_cnt_q < c_vs_end);

    hsync_d       = ~w_hs_region;
    vsync_d       = ~w_vs_region;
    de_d          = w_cur_active;
    rgb_d         = w_cur_active ? w_pixel : 8'h00;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Counter, fetch-index and word-holding registers. Reset parks the raster
  // on its final position so the first free-running cycle is the prefetch
  // for pixel (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q    <= c_h_last;
      v_cnt_q    <= c_v_last;
      word_idx_q <= '0;
      word_q     <= '0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      word_idx_q <= word_idx_d;
      word_q     <= word_d;
    end
  end

  // Registered outputs toward the DAC/pin stage; syncs idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      rgb_q         <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire
